// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - parallel-load serializer with pacing, abort and frame-done pulse
//
// Loads a WIDTH-bit word on a load_valid/load_ready handshake, shifts it out one bit
// per sampled shift_en, then pulses frame_done for one cycle before accepting the
// next word.
//
// Parameters:
//   WIDTH      shift register length in bits (2..64)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   reset       in   asynchronous active-high reset
//   load_valid  in   parallel word offered
//   load_data   in   parallel word to serialize (sampled only on acceptance)
//   load_ready  out  controller can accept a word (IDLE)
//   shift_en    in   pacing tick, one bit advanced per sampled high in SHIFT
//   abort       in   synchronous frame cancel, honoured in SHIFT only
//   sout        out  current serial bit (0 outside SHIFT)
//   sout_valid  out  sout carries a frame bit
//   bit_cnt     out  bits already shifted out in the current frame (0..WIDTH)
//   busy        out  frame in progress (SHIFT or DONE)
//   frame_done  out  one-cycle pulse after the last bit completes

module shift_reg_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    output logic [CW-1:0]    bit_cnt,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    bit_cnt_q;
    logic             load_ready_q;
    logic             sout_valid_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             out_bit;

    // Shift one place toward the output end, filling with zero so that the
    // register is empty once the whole frame has been sent.
    always_comb begin
        shreg_d = shreg_q;
        if (MSB_FIRST != 0) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        out_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    end

    // Status outputs are registered alongside the state so they never glitch;
    // each branch sets them to the values belonging to the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            load_ready_q <= 1'b1;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        state_q      <= SHIFT;
                        shreg_q      <= load_data;
                        bit_cnt_q    <= '0;
                        load_ready_q <= 1'b0;
                        sout_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        // Cancel wins over a simultaneous tick, even on the last bit.
                        state_q      <= IDLE;
                        shreg_q      <= '0;
                        bit_cnt_q    <= '0;
                        load_ready_q <= 1'b1;
                        sout_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (shift_en) begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_IDX) begin
                            state_q      <= DONE;
                            sout_valid_q <= 1'b0;
                            frame_done_q <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state_q      <= IDLE;
                    shreg_q      <= '0;
                    bit_cnt_q    <= '0;
                    load_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end

                default: begin
                    state_q      <= IDLE;
                    shreg_q      <= '0;
                    bit_cnt_q    <= '0;
                    load_ready_q <= 1'b1;
                    sout_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign sout_valid = sout_valid_q;
    assign sout       = sout_valid_q & out_bit;
    assign bit_cnt    = bit_cnt_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - directed self-checking bench for shift_reg_ctrl

module tb_shift_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset;

    logic       load_valid, shift_en, abort;
    logic [7:0] load_data;
    logic       load_ready, sout, sout_valid, busy, frame_done;
    logic [3:0] bit_cnt;

    logic       b_load_valid, b_shift_en, b_abort;
    logic [7:0] b_load_data;
    logic       b_load_ready, b_sout, b_sout_valid, b_busy, b_frame_done;
    logic [3:0] b_bit_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .shift_en(shift_en), .abort(abort),
        .sout(sout), .sout_valid(sout_valid), .bit_cnt(bit_cnt),
        .busy(busy), .frame_done(frame_done)
    );

    shift_reg_ctrl #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset),
        .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
        .shift_en(b_shift_en), .abort(b_abort),
        .sout(b_sout), .sout_valid(b_sout_valid), .bit_cnt(b_bit_cnt),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".load_ready"}, 64'(load_ready), 64'd1);
        chk({tag, ".sout"},       64'(sout),       64'd0);
        chk({tag, ".sout_valid"}, 64'(sout_valid), 64'd0);
        chk({tag, ".busy"},       64'(busy),       64'd0);
        chk({tag, ".frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, ".bit_cnt"},    64'(bit_cnt),    64'd0);
    endtask

    initial begin
        logic [7:0]  word;
        logic [15:0] col;
        logic [7:0]  col8;
        int          acc_n;
        int          acc_k [2];
        int          fd_n;

        reset = 1'b1;
        load_valid = 1'b0; load_data = 8'h00; shift_en = 1'b0; abort = 1'b0;
        b_load_valid = 1'b0; b_load_data = 8'h00; b_shift_en = 1'b0; b_abort = 1'b0;
        acc_k[0] = 0; acc_k[1] = 0;

        // Reset state, with a load offered that must be ignored.
        step();
        load_valid = 1'b1; load_data = 8'hA5;
        step();
        chk_idle("rst");
        chk("rst.b_load_ready", 64'(b_load_ready), 64'd1);
        chk("rst.b_busy",       64'(b_busy),       64'd0);

        // 0xA5 MSB first at full rate, accepted on the first edge after reset release.
        reset = 1'b0; shift_en = 1'b1;
        step();
        chk("a5.accept.busy",       64'(busy),       64'd1);
        chk("a5.accept.load_ready", 64'(load_ready), 64'd0);
        chk("a5.accept.sout_valid", 64'(sout_valid), 64'd1);
        load_valid = 1'b0;
        word = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5.sout[%0d]", i),       64'(sout),       64'(word[7-i]));
            chk($sformatf("a5.bit_cnt[%0d]", i),    64'(bit_cnt),    64'(i));
            chk($sformatf("a5.frame_done[%0d]", i), 64'(frame_done), 64'd0);
            step();
        end
        chk("a5.done.frame_done", 64'(frame_done), 64'd1);
        chk("a5.done.sout_valid", 64'(sout_valid), 64'd0);
        chk("a5.done.sout",       64'(sout),       64'd0);
        chk("a5.done.busy",       64'(busy),       64'd1);
        chk("a5.done.load_ready", 64'(load_ready), 64'd0);
        chk("a5.done.bit_cnt",    64'(bit_cnt),    64'd8);
        step();
        chk_idle("a5.idle");

        // Back-to-back frames with load_valid held and load_data wiggled while busy.
        load_valid = 1'b1; load_data = 8'h3C; shift_en = 1'b1;
        col = 16'h0; acc_n = 0; fd_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (load_ready && load_valid) begin
                if (acc_n < 2) acc_k[acc_n] = k;
                acc_n++;
            end
            step();
            if (sout_valid) col = {col[14:0], sout};
            if (frame_done) fd_n++;
            if (k == 2) load_data = 8'h77;
            if (k == 7) load_data = 8'hC3;
            if (acc_n == 2) load_valid = 1'b0;
        end
        chk("b2b.accepts",    64'(acc_n),               64'd2);
        chk("b2b.spacing",    64'(acc_k[1] - acc_k[0]), 64'd10);
        chk("b2b.serial",     64'(col),                 64'h3CC3);
        chk("b2b.frame_done", 64'(fd_n),                64'd2);
        chk("b2b.load_ready", 64'(load_ready),          64'd1);

        // Abort after four shifts of 0xFF, then an immediate new load.
        load_valid = 1'b1; load_data = 8'hFF;
        step();
        load_valid = 1'b0;
        repeat (4) step();
        chk("abt.bit_cnt", 64'(bit_cnt), 64'd4);
        chk("abt.sout",    64'(sout),    64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abt.idle");
        load_valid = 1'b1; load_data = 8'h5A;
        step();
        load_valid = 1'b0;
        chk("abt.reload.busy",    64'(busy),    64'd1);
        chk("abt.reload.sout",    64'(sout),    64'd0);
        chk("abt.reload.bit_cnt", 64'(bit_cnt), 64'd0);
        fd_n = 0;
        repeat (9) begin
            step();
            if (frame_done) fd_n++;
        end
        chk("abt.reload.frame_done", 64'(fd_n),       64'd1);
        chk("abt.reload.load_ready", 64'(load_ready), 64'd1);

        // Abort and shift_en together on the last bit.
        load_valid = 1'b1; load_data = 8'hFE;
        step();
        load_valid = 1'b0;
        repeat (7) step();
        chk("abt7.bit_cnt", 64'(bit_cnt), 64'd7);
        chk("abt7.sout",    64'(sout),    64'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abt7.idle");
        step();
        chk("abt7.later.frame_done", 64'(frame_done), 64'd0);
        chk("abt7.later.busy",       64'(busy),       64'd0);

        // Asynchronous reset at bit_cnt=5, then a fresh 0x81 frame.
        load_valid = 1'b1; load_data = 8'h42;
        step();
        load_valid = 1'b0;
        repeat (5) step();
        chk("rst5.bit_cnt", 64'(bit_cnt), 64'd5);
        #2 reset = 1'b1;
        #1;
        chk_idle("rst5.async");
        @(negedge clk);
        reset = 1'b0;
        load_valid = 1'b1; load_data = 8'h81;
        step();
        load_valid = 1'b0;
        chk("r81.accept.busy", 64'(busy), 64'd1);
        col8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            col8 = {col8[6:0], sout};
            step();
        end
        chk("r81.serial",     64'(col8),       64'h81);
        chk("r81.frame_done", 64'(frame_done), 64'd1);
        step();
        chk_idle("r81.idle");

        // LSB-first 0x01 with a shift tick every third cycle.
        shift_en = 1'b0;
        b_load_valid = 1'b1; b_load_data = 8'h01; b_shift_en = 1'b0;
        step();
        b_load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("lsb.sout[%0d.%0d]", i, c),    64'(b_sout),    64'(i == 0));
                chk($sformatf("lsb.bit_cnt[%0d.%0d]", i, c), 64'(b_bit_cnt), 64'(i));
                b_shift_en = (c == 2);
                step();
            end
        end
        b_shift_en = 1'b0;
        chk("lsb.frame_done", 64'(b_frame_done), 64'd1);
        chk("lsb.bit_cnt8",   64'(b_bit_cnt),    64'd8);
        step();
        chk("lsb.load_ready", 64'(b_load_ready), 64'd1);
        chk("lsb.fd_clear",   64'(b_frame_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
